alu_ctrl_unit: RTL and testbench

- RV32I ALU control decoder with a registered output stage.
- Maps the main-decoder ALUOp class plus funct = {funct7[5], funct3} to a 4-bit ALU operation select.
- Sits between the instruction decoder and the ALU; adds one pipeline cycle and flags encodings that cannot be decoded.

---
 rtl/alu_ctrl_unit.sv | 123 ++++++++++++
 tb/tb_alu_ctrl_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: RV32I ALU control decoder with one registered output stage.
// Maps the ALUOp class plus funct = {funct7[5], funct3} to a 4-bit ALU select
// and flags combinations that cannot be decoded.
// Optional macro ALU_CTRL_STICKY_ERR_EN adds a sticky_err output that latches
// any registered illegal input until reset.

module alu_ctrl_unit #(
  parameter logic [3:0] ILLEGAL_SEL = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] ALUOp,
  input  logic [3:0] funct,
  output logic [3:0] ALUSel,
  output logic       out_valid,
  output logic       illegal
`ifdef ALU_CTRL_STICKY_ERR_EN
  ,
  output logic       sticky_err
`endif
);

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_SLL  = 4'b0010;
  localparam logic [3:0] SEL_SLT  = 4'b0011;
  localparam logic [3:0] SEL_SLTU = 4'b0100;
  localparam logic [3:0] SEL_XOR  = 4'b0101;
  localparam logic [3:0] SEL_SRL  = 4'b0110;
  localparam logic [3:0] SEL_SRA  = 4'b0111;
  localparam logic [3:0] SEL_OR   = 4'b1000;
  localparam logic [3:0] SEL_AND  = 4'b1001;

  logic [3:0] next_sel;
  logic       next_illegal;

  // Pure combinational decode of the current ALUOp/funct pair.
  always_comb begin
    next_sel     = SEL_ADD;
    next_illegal = 1'b0;
    case (ALUOp)
      2'b00: begin
        next_sel = SEL_ADD;
      end
      2'b01: begin
        case (funct)
          4'b0000: next_sel = SEL_ADD;
          4'b1000: next_sel = SEL_SUB;
          4'b0001: next_sel = SEL_SLL;
          4'b0010: next_sel = SEL_SLT;
          4'b0011: next_sel = SEL_SLTU;
          4'b0100: next_sel = SEL_XOR;
          4'b0101: next_sel = SEL_SRL;
          4'b1101: next_sel = SEL_SRA;
          4'b0110: next_sel = SEL_OR;
          4'b0111: next_sel = SEL_AND;
          default: begin
            next_sel     = ILLEGAL_SEL;
            next_illegal = 1'b1;
          end
        endcase
      end
      2'b10: begin
        case (funct[2:0])
          3'b000: next_sel = SEL_ADD;
          3'b001: begin
            if (funct[3]) begin
              next_sel     = ILLEGAL_SEL;
              next_illegal = 1'b1;
            end else begin
              next_sel = SEL_SLL;
            end
          end
          3'b010: next_sel = SEL_SLT;
          3'b011: next_sel = SEL_SLTU;
          3'b100: next_sel = SEL_XOR;
          3'b101: next_sel = funct[3] ? SEL_SRA : SEL_SRL;
          3'b110: next_sel = SEL_OR;
          3'b111: next_sel = SEL_AND;
        endcase
      end
      2'b11: begin
        case (funct[2:0])
          3'b000, 3'b001: next_sel = SEL_SUB;
          3'b100, 3'b101: next_sel = SEL_SLT;
          3'b110, 3'b111: next_sel = SEL_SLTU;
          default: begin
            next_sel     = ILLEGAL_SEL;
            next_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Output stage: valid follows in_valid, select/flag update only on valid input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUSel    <= SEL_ADD;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ALUSel  <= next_sel;
        illegal <= next_illegal;
      end
    end
  end

`ifdef ALU_CTRL_STICKY_ERR_EN
  // Latch any accepted illegal input; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_err <= 1'b0;
    end else if (in_valid && next_illegal) begin
      sticky_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// tb_alu_ctrl_unit: directed self-checking bench for alu_ctrl_unit.
// Expected results are queued when a step is driven and popped after the edge.
// Define ALU_CTRL_STICKY_ERR_EN to also exercise the sticky_err output.

module tb_alu_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] ALUOp = 2'b00;
  logic [3:0] funct = 4'b0000;
  logic [3:0] ALUSel;
  logic       out_valid;
  logic       illegal;
`ifdef ALU_CTRL_STICKY_ERR_EN
  logic       sticky_err;
`endif

  typedef struct {
    string      tag;
    logic [3:0] sel;
    logic       vld;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  alu_ctrl_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ALUOp     (ALUOp),
    .funct     (funct),
    .ALUSel    (ALUSel),
    .out_valid (out_valid),
    .illegal   (illegal)
`ifdef ALU_CTRL_STICKY_ERR_EN
    ,
    .sticky_err(sticky_err)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Compare all three outputs against the supplied expectation.
  task automatic check_output(input string tag, input logic [3:0] sel,
                              input logic vld, input logic ill);
    n_checks++;
    assert (ALUSel === sel) else begin
      n_fail++;
      $error("[TB] FAIL %s ALUSel observed %b expected %b", tag, ALUSel, sel);
    end
    n_checks++;
    assert (out_valid === vld) else begin
      n_fail++;
      $error("[TB] FAIL %s out_valid observed %b expected %b", tag, out_valid, vld);
    end
    n_checks++;
    assert (illegal === ill) else begin
      n_fail++;
      $error("[TB] FAIL %s illegal observed %b expected %b", tag, illegal, ill);
    end
  endtask

  // Drive one cycle of input, queue its expectation, check it after the edge.
  task automatic apply_stimulus(input string tag, input logic v,
                                input logic [1:0] op, input logic [3:0] f,
                                input logic [3:0] sel, input logic ill);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    ALUOp    = op;
    funct    = f;
    e.tag = tag;
    e.sel = sel;
    e.vld = v;
    e.ill = ill;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("[TB] FAIL %s scoreboard observed empty expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check_output(e.tag, e.sel, e.vld, e.ill);
    end
  endtask

`ifdef ALU_CTRL_STICKY_ERR_EN
  task automatic check_sticky(input string tag, input logic exp_val);
    n_checks++;
    assert (sticky_err === exp_val) else begin
      n_fail++;
      $error("[TB] FAIL %s sticky_err observed %b expected %b", tag, sticky_err, exp_val);
    end
  endtask
`endif

  // Directed test sequence.
  initial begin
    // Reset held while inputs toggle.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      ALUOp    = 2'($urandom_range(0, 3));
      funct    = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check_output("reset_hold", 4'b0000, 1'b0, 1'b0);
    end
`ifdef ALU_CTRL_STICKY_ERR_EN
    check_sticky("sticky_reset", 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    apply_stimulus("first_add",  1'b1, 2'b01, 4'b0000, 4'b0000, 1'b0);

    // R-type sweep.
    apply_stimulus("r_sub",      1'b1, 2'b01, 4'b1000, 4'b0001, 1'b0);
    apply_stimulus("r_sll",      1'b1, 2'b01, 4'b0001, 4'b0010, 1'b0);
    apply_stimulus("r_slt",      1'b1, 2'b01, 4'b0010, 4'b0011, 1'b0);
    apply_stimulus("r_sltu",     1'b1, 2'b01, 4'b0011, 4'b0100, 1'b0);
    apply_stimulus("r_xor",      1'b1, 2'b01, 4'b0100, 4'b0101, 1'b0);
    apply_stimulus("r_srl",      1'b1, 2'b01, 4'b0101, 4'b0110, 1'b0);
    apply_stimulus("r_sra",      1'b1, 2'b01, 4'b1101, 4'b0111, 1'b0);
    apply_stimulus("r_or",       1'b1, 2'b01, 4'b0110, 4'b1000, 1'b0);
    apply_stimulus("r_and",      1'b1, 2'b01, 4'b0111, 4'b1001, 1'b0);
    apply_stimulus("r_ill_1001", 1'b1, 2'b01, 4'b1001, 4'b0000, 1'b1);
    apply_stimulus("r_xor2",     1'b1, 2'b01, 4'b0100, 4'b0101, 1'b0);
    apply_stimulus("r_ill_1100", 1'b1, 2'b01, 4'b1100, 4'b0000, 1'b1);
    apply_stimulus("r_ill_1111", 1'b1, 2'b01, 4'b1111, 4'b0000, 1'b1);

    // Load/store and I-type.
    apply_stimulus("ls_add",     1'b1, 2'b00, 4'b1011, 4'b0000, 1'b0);
    apply_stimulus("i_ill_slli", 1'b1, 2'b10, 4'b1001, 4'b0000, 1'b1);
    apply_stimulus("i_sra",      1'b1, 2'b10, 4'b1101, 4'b0111, 1'b0);
    apply_stimulus("i_or_f7",    1'b1, 2'b10, 4'b1110, 4'b1000, 1'b0);
    apply_stimulus("i_sll",      1'b1, 2'b10, 4'b0001, 4'b0010, 1'b0);
    apply_stimulus("i_srl",      1'b1, 2'b10, 4'b0101, 4'b0110, 1'b0);
    apply_stimulus("i_add_f7",   1'b1, 2'b10, 4'b1000, 4'b0000, 1'b0);
    apply_stimulus("i_sltu",     1'b1, 2'b10, 4'b0011, 4'b0100, 1'b0);

    // Branch.
    apply_stimulus("b_sub",      1'b1, 2'b11, 4'b0001, 4'b0001, 1'b0);
    apply_stimulus("b_slt",      1'b1, 2'b11, 4'b0101, 4'b0011, 1'b0);
    apply_stimulus("b_sltu",     1'b1, 2'b11, 4'b0111, 4'b0100, 1'b0);
    apply_stimulus("b_ill_010",  1'b1, 2'b11, 4'b0010, 4'b0000, 1'b1);
    apply_stimulus("b_ill_1011", 1'b1, 2'b11, 4'b1011, 4'b0000, 1'b1);

    // Illegal flag holds while in_valid is low.
    apply_stimulus("ill_hold",   1'b0, 2'b01, 4'b0111, 4'b0000, 1'b1);

    // Hold: register AND then idle with random inputs.
    apply_stimulus("hold_load",  1'b1, 2'b01, 4'b0111, 4'b1001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus("hold_idle", 1'b0, 2'($urandom_range(0, 3)),
                     4'($urandom_range(0, 15)), 4'b1001, 1'b0);
    end

    // Mid-stream reset clears outputs without a clock edge.
    apply_stimulus("pre_reset",  1'b1, 2'b01, 4'b0110, 4'b1000, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("post_reset", 1'b1, 2'b10, 4'b0100, 4'b0101, 1'b0);

`ifdef ALU_CTRL_STICKY_ERR_EN
    // Sticky error survives legal traffic and clears only on reset.
    check_sticky("sticky_clear", 1'b0);
    apply_stimulus("st_ill",     1'b1, 2'b11, 4'b0011, 4'b0000, 1'b1);
    check_sticky("sticky_set", 1'b1);
    apply_stimulus("st_legal1",  1'b1, 2'b01, 4'b0000, 4'b0000, 1'b0);
    apply_stimulus("st_legal2",  1'b1, 2'b10, 4'b0110, 4'b1000, 1'b0);
    check_sticky("sticky_keep", 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_sticky("sticky_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("st_after",   1'b1, 2'b01, 4'b0000, 4'b0000, 1'b0);
    check_sticky("sticky_after", 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
